// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter generator.
// Holds the FSM state encoding and the redirect-index width helper.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // A single redirect source still needs a 1-bit index port.
    function automatic int redir_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pc_gen_dff.sv
// Enable-capable flop with synchronous active-low reset.
// The reset value is a vector input, so it can come from a port.
module pc_gen_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest asserted index wins.
// Purely combinational; produces a one-hot grant, its index and an any-valid flag.
module redir_arb
    import pc_gen_pkg::*;
#(
    parameter int NUM_REDIR = 2
) (
    input  logic [NUM_REDIR-1:0]                     valid_i,
    output logic [NUM_REDIR-1:0]                     grant_o,
    output logic [redir_idx_w(NUM_REDIR)-1:0]        idx_o,
    output logic                                     any_o
);

    localparam int IW = redir_idx_w(NUM_REDIR);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |valid_i;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                idx_o      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT control, prioritised
// redirects, misalignment detection and a valid/ready handshake to fetch.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INC_AMOUNT = 4,
    parameter int NUM_REDIR  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PC_WIDTH-1:0]                   reset_vector,
    input  logic [NUM_REDIR-1:0]                  redir_valid,
    input  logic [NUM_REDIR-1:0][PC_WIDTH-1:0]    redir_pc,
    input  logic                                  halt_req,
    input  logic                                  resume,
    input  logic                                  pc_ready,
    output logic [PC_WIDTH-1:0]                   pc_out,
    output logic                                  pc_valid,
    output logic [redir_idx_w(NUM_REDIR)-1:0]     redir_idx,
    output logic                                  redir_taken,
    output logic                                  misalign_err,
    output logic                                  halted
);

    localparam int IW = redir_idx_w(NUM_REDIR);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INC_AMOUNT - 1);
    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INC_AMOUNT);

    pc_state_e            state_q;
    pc_state_e            state_d;
    logic [1:0]           stateRaw;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  pc_d;
    logic                 pcEn;

    logic [NUM_REDIR-1:0] grant;
    logic [IW-1:0]        winIdx;
    logic                 anyRedir;
    logic [PC_WIDTH-1:0]  target;
    logic                 misaligned;
    logic                 redirLoad;
    logic                 handshake;

    logic                 redir_taken_q;
    logic                 misalign_err_q;
    logic [IW-1:0]        redir_idx_q;

    redir_arb #(
        .NUM_REDIR (NUM_REDIR)
    ) u_arb (
        .valid_i (redir_valid),
        .grant_o (grant),
        .idx_o   (winIdx),
        .any_o   (anyRedir)
    );

    // One-hot mux of the winning target, then classify the redirect.
    always_comb begin
        target = '0;
        for (int i = 0; i < NUM_REDIR; i++) begin
            if (grant[i]) begin
                target = target | redir_pc[i];
            end
        end
        misaligned = anyRedir && ((target & ALIGN_MASK) != '0);
        redirLoad  = anyRedir && !misaligned;
        handshake  = (state_q == ST_RUN) && pc_ready;
    end

    always_comb begin
        pc_d = pc_q;
        pcEn = 1'b0;
        if (redirLoad) begin
            pc_d = target;
            pcEn = 1'b1;
        end else if (handshake) begin
            pc_d = pc_q + INC;
            pcEn = 1'b1;
        end
    end

    // A misaligned target halts from any state; halt_req beats resume in HALT.
    always_comb begin
        state_d = state_q;
        if (misaligned) begin
            state_d = ST_HALT;
        end else begin
            unique case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  state_d = halt_req ? ST_HALT : ST_RUN;
                ST_HALT: state_d = (!halt_req && resume) ? ST_RUN : ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    pc_gen_dff #(.W(PC_WIDTH)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pcEn),
        .rst_val (reset_vector),
        .d       (pc_d),
        .q       (pc_q)
    );

    pc_gen_dff #(.W(2)) u_state_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (1'b1),
        .rst_val (ST_BOOT),
        .d       (state_d),
        .q       (stateRaw)
    );

    assign state_q = pc_state_e'(stateRaw);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redir_taken_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            redir_idx_q    <= '0;
        end else begin
            redir_taken_q  <= redirLoad;
            misalign_err_q <= misaligned;
            redir_idx_q    <= winIdx;
        end
    end

    assign pc_out       = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);
    assign redir_taken  = redir_taken_q;
    assign misalign_err = misalign_err_q;
    assign redir_idx    = redir_idx_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      reset_vector;
    logic [1:0]       redir_valid;
    logic [1:0][31:0] redir_pc;
    logic             halt_req;
    logic             resume;
    logic             pc_ready;
    logic [31:0]      pc_out;
    logic             pc_valid;
    logic [0:0]       redir_idx;
    logic             redir_taken;
    logic             misalign_err;
    logic             halted;

    int compared   = 0;
    int mismatched = 0;

    pc_gen #(
        .PC_WIDTH   (32),
        .INC_AMOUNT (4),
        .NUM_REDIR  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reset_vector (reset_vector),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_ready     (pc_ready),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .redir_idx    (redir_idx),
        .redir_taken  (redir_taken),
        .misalign_err (misalign_err),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] expPc, input logic expValid,
                            input logic expHalted, input logic expTaken, input logic expMis);
        checkOutput({tag, ".pc"},       pc_out,       expPc);
        checkOutput({tag, ".valid"},    pc_valid,     expValid);
        checkOutput({tag, ".halted"},   halted,       expHalted);
        checkOutput({tag, ".taken"},    redir_taken,  expTaken);
        checkOutput({tag, ".misalign"}, misalign_err, expMis);
    endtask

    initial begin
        rst_n        = 1'b0;
        reset_vector = 32'h0000_1000;
        redir_valid  = 2'b00;
        redir_pc     = '0;
        halt_req     = 1'b0;
        resume       = 1'b0;
        pc_ready     = 1'b1;

        // Reset and boot
        tick();
        tick();
        checkAll("reset", 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.idx", redir_idx, 1'b0);
        rst_n = 1'b1;
        tick();
        checkAll("boot", 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("inc1", pc_out, 32'h1004);
        tick();
        checkOutput("inc2", pc_out, 32'h1008);

        // Backpressure at 0x2000
        pc_ready    = 1'b0;
        redir_valid = 2'b01;
        redir_pc[0] = 32'h2000;
        tick();
        checkAll("redir2000", 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0);
        redir_valid = 2'b00;
        tick();
        checkAll("hold1", 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("hold3", pc_out, 32'h2000);
        pc_ready = 1'b1;
        tick();
        checkOutput("readyback", pc_out, 32'h2004);

        // Priority between two sources, ready low
        pc_ready    = 1'b0;
        redir_valid = 2'b11;
        redir_pc[1] = 32'h3000;
        redir_pc[0] = 32'h4000;
        tick();
        checkAll("prio", 32'h4000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("prio.idx", redir_idx, 1'b0);
        redir_valid = 2'b00;
        tick();
        checkOutput("prio.pulse", redir_taken, 1'b0);
        redir_valid = 2'b10;
        tick();
        checkAll("src1", 32'h3000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("src1.idx", redir_idx, 1'b1);
        redir_valid = 2'b00;

        // Misaligned target halts without moving the PC
        redir_valid = 2'b01;
        redir_pc[0] = 32'h5002;
        tick();
        checkAll("misalign", 32'h3000, 1'b0, 1'b1, 1'b0, 1'b1);
        redir_valid = 2'b00;
        pc_ready    = 1'b1;
        tick();
        checkAll("halt.stay", 32'h3000, 1'b0, 1'b1, 1'b0, 1'b0);
        pc_ready = 1'b0;
        resume   = 1'b1;
        tick();
        resume = 1'b0;
        checkAll("resume", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Halt together with a redirect
        halt_req    = 1'b1;
        redir_valid = 2'b01;
        redir_pc[0] = 32'h6000;
        tick();
        checkAll("haltredir", 32'h6000, 1'b0, 1'b1, 1'b1, 1'b0);
        redir_valid = 2'b00;
        resume      = 1'b1;
        tick();
        checkOutput("haltwins", halted, 1'b1);
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        checkAll("resume2", 32'h6000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Handshake in the same cycle as halt_req still increments
        pc_ready = 1'b1;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checkAll("halt.inc", 32'h6004, 1'b0, 1'b1, 1'b0, 1'b0);
        pc_ready = 1'b0;
        resume   = 1'b1;
        tick();
        resume = 1'b0;

        // Wraparound
        redir_valid = 2'b01;
        redir_pc[0] = 32'hFFFF_FFFC;
        tick();
        redir_valid = 2'b00;
        checkOutput("wrap.pre", pc_out, 32'hFFFF_FFFC);
        pc_ready = 1'b1;
        tick();
        checkOutput("wrap", pc_out, 32'h0000_0000);

        // Reset overrides a pending redirect and handshake
        redir_valid = 2'b01;
        redir_pc[0] = 32'h7000;
        rst_n       = 1'b0;
        tick();
        checkAll("rst.redir", 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        redir_valid = 2'b00;

        // halt_req ignored in BOOT
        rst_n    = 1'b1;
        halt_req = 1'b1;
        pc_ready = 1'b0;
        tick();
        halt_req = 1'b0;
        checkAll("boot.ignore", 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
Parameters:
REQ-001 The block SHALL provide parameter PC_WIDTH, default 32, the program counter width in bits.
REQ-002 The block SHALL provide parameter INC_AMOUNT, default 4, the sequential increment; it must be a power of two.
REQ-003 The block SHALL provide parameter NUM_REDIR, default 2, the number of redirect sources; index 0 has the highest priority.

Ports:
REQ-004 The block SHALL have one clock, clk; reset rst_n is synchronous and active-low.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- reset_vector  in  PC_WIDTH  PC loaded at reset
- redir_valid  in  NUM_REDIR  per-source redirect request
- redir_pc  in  NUM_REDIR x PC_WIDTH  per-source target
- halt_req  in  1  request to stop issuing
- resume  in  1  leave HALT
- pc_ready  in  1  fetch accepts pc_out
- pc_out  out  PC_WIDTH  current PC
- pc_valid  out  1  pc_out offered to fetch
- redir_idx  out  clog2(NUM_REDIR), min 1  index of the winning redirect, valid while redir_taken is high
- redir_taken  out  1  one-cycle pulse when a redirect loads
- misalign_err  out  1  one-cycle pulse on a misaligned redirect target
- halted  out  1  high in state HALT

Function
REQ-006 The block SHALL implement states BOOT, RUN and HALT.
REQ-007 After reset the state SHALL be BOOT, with pc_out = reset_vector and pc_valid = 0.
REQ-008 BOOT SHALL unconditionally move to RUN on the next cycle.
REQ-009 pc_valid SHALL be 1 only in RUN.
REQ-010 In RUN, the handshake pc_valid & pc_ready SHALL load pc_out + INC_AMOUNT, modulo 2^PC_WIDTH; 0xFFFF_FFFC SHALL wrap to 0x0000_0000.
REQ-011 While pc_valid = 1 and pc_ready = 0, pc_out SHALL hold stable unless a redirect loads.
REQ-012 A redirect SHALL be selected as the lowest asserted index of redir_valid; all other sources SHALL be ignored that cycle.
REQ-013 A redirect SHALL take priority over increment and be independent of pc_ready.
REQ-014 An aligned redirect target (low log2(INC_AMOUNT) bits zero) SHALL load pc_out on the next edge and pulse redir_taken with redir_idx.
REQ-015 A redirect SHALL be accepted in BOOT, RUN and HALT, and SHALL not change the state.
REQ-016 A misaligned winning target SHALL leave pc_out unchanged, pulse misalign_err, leave redir_taken at 0, and move the state to HALT.
REQ-017 halt_req in RUN SHALL move the state to HALT on the next edge.
REQ-018 A handshake in the same cycle as halt_req SHALL still increment pc_out.
REQ-019 resume in HALT SHALL return the state to RUN; halt_req SHALL take priority over a simultaneous resume.
REQ-020 halt_req and resume SHALL be ignored in BOOT.
REQ-021 halted SHALL equal (state == HALT).
REQ-022 Outputs SHALL be registered except pc_valid and halted, which decode the state register only.

Reset
REQ-023 When rst_n = 0 at an edge, the block SHALL set state = BOOT, pc_out = reset_vector, and redir_taken = misalign_err = redir_idx = 0.
REQ-024 Reset SHALL override every simultaneous request, including mid-handshake and mid-redirect.

Structure
REQ-025 Package pc_gen_pkg SHALL hold the state enum typedef (pc_state_e) and the helper function for the redirect index width.
REQ-026 The PC and state registers SHALL use the library's enable-capable synchronous-reset flop with a vector reset value.
REQ-027 The priority select SHALL be sub-module redir_arb (NUM_REDIR requests -> one-hot grant, index and any-valid), with no internal state.

Verification
REQ-028 Reset and boot: reset_vector = 0x1000, rst_n low 2 cycles then released -> pc_valid 0 in cycle 1, then 1 with pc_out = 0x1000; pc_ready held high -> 0x1004, 0x1008.
REQ-029 Backpressure: pc_ready = 0 for 3 cycles at 0x2000 -> pc_out holds at 0x2000 with pc_valid high; ready returns -> 0x2004.
REQ-030 Priority: redir_valid = 2'b11 with redir_pc = {0x3000, 0x4000} and pc_ready = 0 -> pc_out = 0x4000 (source 0), redir_idx = 0, redir_taken single pulse.
REQ-031 Misalignment: redirect target 0x5002 -> pc_out unchanged, misalign_err single pulse, halted = 1, pc_valid = 0; resume -> RUN at the old PC.
REQ-032 Halt interplay: halt_req and a redirect to 0x6000 in the same cycle -> HALT with pc_out = 0x6000; resume -> pc_valid = 1 at 0x6000.
REQ-033 Wrap and reset: pc at 0xFFFF_FFFC with a handshake -> 0x0000_0000; rst_n low during a pending redirect -> pc_out = reset_vector, state BOOT.
